usb_tx_encoder: RTL

//  USB full-speed transmit line encoder; the transmit-side counterpart of the Rx NRZI decode path.

---
 rtl/usb_tx_pkg.sv | 29 ++
 rtl/usb_tx_if.sv | 24 ++
 rtl/usb_tx_bit_timer.sv | 26 ++
 rtl/usb_tx_encoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// The optional on-chip SYNC generator is enabled with the USB_TX_SYNC_EN macro.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      STUFF,
      EOP_SE0,
      EOP_J
   } state_t;

   typedef enum logic [1:0] {
      J,
      K,
      SE0
   } line_t;

   localparam logic [7:0] SYNC_BYTE    = 8'h80;
   localparam int         EOP_SE0_BITS = 2;

   // NRZI: a 0 toggles between J and K, a 1 holds the line.
   function automatic line_t nrzi_next(input line_t cur, input logic b);
      if (b) return cur;
      return (cur == J) ? K : J;
   endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Packet-shifter to line-encoder connection: serial bit handshake, status and pad drives.
// Handshake: a bit transfers on a clk edge where tx_valid && tx_ready; tx_last is qualified by that transfer.
interface usb_tx_if;
   logic tx_start;
   logic tx_bit;
   logic tx_valid;
   logic tx_last;
   logic tx_ready;
   logic d_plus;
   logic d_minus;
   logic tx_busy;
   logic tx_done;
   logic tx_err;

   modport master (
      output tx_start, tx_bit, tx_valid, tx_last,
      input  tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err
   );

   modport slave (
      input  tx_start, tx_bit, tx_valid, tx_last,
      output tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err
   );
endinterface

// File: rtl/usb_tx_bit_timer.sv
// Bit-time counter: divides clk into USB bit slots; a slot starts where bit_cnt == 0.
module usb_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_strobe,
   output logic slot_end
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] bit_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         bit_cnt <= '0;
      else if (bit_cnt == CW'(CLKS_PER_BIT - 1))
         bit_cnt <= '0;
      else
         bit_cnt <= bit_cnt + CW'(1);
   end

   assign bit_strobe = (bit_cnt == '0);
   assign slot_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed Tx line encoder: bit stuffing, NRZI, EOP generation.
// Define USB_TX_SYNC_EN to generate the SYNC pattern internally after tx_start.
module usb_tx_encoder
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_ONES     = 6
) (
   input  logic     clk,
   input  logic     rst,
   usb_tx_if.slave  bus,
   output state_t   state_dbg
);
   localparam int OW = $clog2(MAX_ONES + 1);

   state_t        state_q;
   line_t         line_q;
   logic [OW-1:0] ones_q;
   logic          last_pend_q;
   logic [1:0]    eop_cnt_q;
   logic          busy_q;
   logic          done_q;
`ifdef USB_TX_SYNC_EN
   logic [2:0]    sync_idx_q;
`endif

   logic bit_strobe;
   logic slot_end;
   logic stuff_pend;
   logic data_slot;

   usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q == IDLE && bus.tx_start),
      .bit_strobe (bit_strobe),
      .slot_end   (slot_end)
   );

   function automatic logic [OW-1:0] ones_next(input logic [OW-1:0] cur, input logic b);
      if (!b) return '0;
      return (cur == OW'(MAX_ONES)) ? cur : cur + OW'(1);
   endfunction

   assign stuff_pend = (ones_q == OW'(MAX_ONES));
   // A DATA boundary that neither owes a stuffed bit nor closes the packet takes a new bit.
   assign data_slot  = (state_q == DATA) && bit_strobe && !stuff_pend && !last_pend_q;

   assign bus.tx_ready = data_slot;
   assign bus.tx_err   = data_slot && !bus.tx_valid;
   assign bus.d_plus   = (line_q == J);
   assign bus.d_minus  = (line_q == K);
   assign bus.tx_busy  = busy_q;
   assign bus.tx_done  = done_q;
   assign state_dbg    = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         line_q      <= J;
         ones_q      <= '0;
         last_pend_q <= 1'b0;
         eop_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef USB_TX_SYNC_EN
         sync_idx_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               line_q <= J;
               if (bus.tx_start) begin
                  busy_q      <= 1'b1;
                  ones_q      <= '0;
                  last_pend_q <= 1'b0;
                  eop_cnt_q   <= '0;
`ifdef USB_TX_SYNC_EN
                  sync_idx_q  <= '0;
                  state_q     <= SYNC;
`else
                  state_q     <= DATA;
`endif
               end
            end
`ifdef USB_TX_SYNC_EN
            SYNC: if (bit_strobe) begin
               line_q     <= nrzi_next(line_q, SYNC_BYTE[sync_idx_q]);
               ones_q     <= ones_next(ones_q, SYNC_BYTE[sync_idx_q]);
               sync_idx_q <= sync_idx_q + 3'd1;
               if (sync_idx_q == 3'd7) state_q <= DATA;
            end
`endif
            DATA: if (bit_strobe) begin
               if (stuff_pend) begin
                  line_q  <= nrzi_next(line_q, 1'b0);
                  ones_q  <= '0;
                  state_q <= STUFF;
               end else if (last_pend_q || !bus.tx_valid) begin
                  // Normal end of packet or underrun: SE0 starts on this boundary.
                  line_q    <= SE0;
                  eop_cnt_q <= 2'd1;
                  state_q   <= EOP_SE0;
               end else begin
                  line_q      <= nrzi_next(line_q, bus.tx_bit);
                  ones_q      <= ones_next(ones_q, bus.tx_bit);
                  last_pend_q <= bus.tx_last;
               end
            end
            STUFF: if (slot_end) state_q <= DATA;
            EOP_SE0: if (bit_strobe) begin
               if (eop_cnt_q == 2'(EOP_SE0_BITS)) begin
                  line_q  <= J;
                  state_q <= EOP_J;
               end else begin
                  eop_cnt_q <= eop_cnt_q + 2'd1;
               end
            end
            EOP_J: if (bit_strobe) begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               ones_q  <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
